// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
// Frame geometry defaults and receiver state encodings.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 10416;
  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is selectable so idle-high lines stay quiet.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= RST_VAL;
      q_o  <= RST_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check,
// one-cycle valid/frame-error strobes, break hold-off.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       RXD_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

  rx_state_e state_q;
  rx_state_e state_d;

  logic                 rxd_s;
  logic [CW-1:0]        cnt;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (RXD_i),
    .q_o   (rxd_s)
  );

  // START waits half a bit to land mid-bit; later states a full bit
  always_comb begin
    tick = 1'b0;
    if (state_q == RX_START)
      tick = (cnt == HALF_M1);
    else
      tick = (cnt == FULL_M1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_q <= RX_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:
        if (!rxd_s) state_d = RX_START;
      RX_START:
        if (tick) state_d = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (tick && bit_idx == LAST_IDX) state_d = RX_STOP;
      RX_STOP:
        if (tick) state_d = rxd_s ? RX_IDLE : RX_BREAK;
      RX_BREAK:
        if (rxd_s) state_d = RX_IDLE;
      default:
        state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      case (state_q)
        RX_START: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) bit_idx <= '0;
        end
        RX_DATA: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) begin
            shift[bit_idx] <= rxd_s;
            bit_idx        <= bit_idx + BIT_IDX_W'(1);
          end
        end
        RX_STOP: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) begin
            if (rxd_s) begin
              data_o  <= shift;
              valid_o <= 1'b1;
            end else begin
              frame_err_o <= 1'b1;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q != RX_IDLE);
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at a reduced bit period.
// Driver queues expected pulses; a negedge monitor checks them.
module tb_uart_receiver;

  localparam int CPB  = 32;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         lat;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       RXD_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  logic [7:0] last_good = 8'h00;
  exp_t q[$];

  uart_receiver #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .RXD_i       (RXD_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    @(posedge clk_i);
    #1 RXD_i = v;
    repeat (n - 1) @(posedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b, input int per,
                           input logic stop);
    @(posedge clk_i);
    #1 RXD_i = 1'b0;
    fall_cyc = cyc;
    repeat (per - 1) @(posedge clk_i);
    for (int i = 0; i < 8; i++) hold(b[i], per);
    hold(stop, per);
  endtask

  task automatic expect_ok(input logic [7:0] b, input int lat);
    exp_t e;
    e.err = 1'b0;
    e.data = b;
    e.lat = lat;
    q.push_back(e);
    last_good = b;
  endtask

  task automatic expect_err();
    exp_t e;
    e.err = 1'b1;
    e.data = last_good;
    e.lat = 0;
    q.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && (valid_o || frame_err_o)) begin
      exp_t e;
      if (valid_o && frame_err_o)
        check("valid_and_err_same_cycle", 1, 0);
      if (q.size() == 0) begin
        check("unexpected_pulse", {valid_o, frame_err_o}, 0);
      end else begin
        e = q.pop_front();
        check("pulse_kind", int'(frame_err_o), int'(e.err));
        check("pulse_data", int'(data_o), int'(e.data));
        if (e.lat != 0) begin
          tests++;
          if ((cyc - fall_cyc) < e.lat - 1 ||
              (cyc - fall_cyc) > e.lat + 1) begin
            fails++;
            $display("FAIL latency: got %0d expected %0d +-1",
                     cyc - fall_cyc, e.lat);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_data", int'(data_o), 8'h00);
    check("rst_valid", int'(valid_o), 0);
    check("rst_err", int'(frame_err_o), 0);
    check("rst_busy", int'(busy_o), 0);
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);

    expect_ok(8'hA5, LAT);
    send_byte(8'hA5, CPB, 1'b1);
    repeat (CPB) @(posedge clk_i);
    #1 check("a5_data_held", int'(data_o), 8'hA5);

    expect_ok(8'h00, 0);
    send_byte(8'h00, CPB, 1'b1);
    expect_ok(8'hFF, 0);
    send_byte(8'hFF, CPB, 1'b1);
    expect_ok(8'h55, 0);
    send_byte(8'h55, CPB, 1'b1);
    repeat (2 * CPB) @(posedge clk_i);

    hold(1'b0, 6);
    #1 check("glitch_busy_high", int'(busy_o), 1);
    hold(1'b1, 1);
    repeat (HALF + 4) @(posedge clk_i);
    #1 check("glitch_busy_low", int'(busy_o), 0);
    repeat (CPB) @(posedge clk_i);

    expect_err();
    send_byte(8'h3C, CPB, 1'b0);
    hold(1'b0, 5 * CPB);
    #1 check("break_busy", int'(busy_o), 1);
    check("break_data_kept", int'(data_o), 8'h55);
    hold(1'b1, 6);
    #1 check("break_exit", int'(busy_o), 0);
    repeat (CPB) @(posedge clk_i);

    fork
      send_byte(8'hE7, CPB, 1'b1);
      begin
        repeat (5 * CPB + HALF) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("midrst_data", int'(data_o), 8'h00);
        check("midrst_valid", int'(valid_o), 0);
        check("midrst_busy", int'(busy_o), 0);
      end
    join
    last_good = 8'h00;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (CPB) @(posedge clk_i);

    expect_ok(8'h81, 0);
    send_byte(8'h81, CPB, 1'b1);
    repeat (CPB) @(posedge clk_i);

    expect_ok(8'hC3, 0);
    send_byte(8'hC3, CPB - 1, 1'b1);
    repeat (CPB) @(posedge clk_i);
    expect_ok(8'hC3, 0);
    send_byte(8'hC3, CPB + 1, 1'b1);
    repeat (2 * CPB) @(posedge clk_i);

    #1 check("final_data", int'(data_o), 8'hC3);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
